mips32_mem_responder: RTL

Memory-side responder for the two-phase MIPS32 pipeline's instruction-fetch and data-memory accesses. It serves a read-only fetch port and a read/write data port from one shared word-addressed array, arbitrating with fixed priority. It answers each accepted request after a programmable number of wait states using a request/grant, response-valid handshake. The pipeline's IF and MEM stages, or a bus bridge in front of them, are the initiators.

---
 rtl/mips32_mem_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mips32_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips32_mem_responder                                                       |
// | Shared fetch/data word memory with fixed-priority arbitration and          |
// | programmable wait states. Optional MEMRESP_ERR_EN adds the err response.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mips32_mem_responder #(
  parameter int AW   = 10,
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        busy
`ifdef MEMRESP_ERR_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0]  c_wait_init = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
  localparam logic [31:0] c_err_word  = 32'hDEADBEEF;

  logic [31:0] mem [0:(2**AW)-1];

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_port_d;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_i_rvalid;
  logic        r_d_rvalid;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        r_err;

  logic        w_i_gnt;
  logic        w_d_gnt;
  logic        w_sel_d;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_enter_resp;
  logic        w_oor;
  logic        w_wr_en;
  logic [31:0] w_resp_word;
  logic [AW-1:0] w_idx;

  // In IDLE the granted request is used directly so WAIT=0 can respond next cycle.
  always_comb begin
    w_next       = r_state;
    w_i_gnt      = 1'b0;
    w_d_gnt      = 1'b0;
    w_sel_d      = r_port_d;
    w_sel_we     = r_we;
    w_sel_addr   = r_addr;
    w_sel_wdata  = r_wdata;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_d_gnt     = d_req;
        w_i_gnt     = i_req & ~d_req;
        w_sel_d     = d_req;
        w_sel_we    = d_req & d_we;
        w_sel_addr  = d_req ? d_addr : i_addr;
        w_sel_wdata = d_wdata;
        if (d_req || i_req) begin
          if (WAIT == 0) begin
            w_next       = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next       = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef MEMRESP_ERR_EN
  assign w_oor = |w_sel_addr[31:AW];
`else
  logic w_unused_hi;
  assign w_oor       = 1'b0;
  assign w_unused_hi = ^w_sel_addr[31:AW];
`endif

  assign w_idx       = w_sel_addr[AW-1:0];
  assign w_wr_en     = w_enter_resp & w_sel_we & ~w_oor;
  assign w_resp_word = w_oor ? c_err_word : (w_sel_we ? w_sel_wdata : mem[w_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_port_d   <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= 32'd0;
      r_d_rdata  <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && (d_req || i_req)) begin
        r_cnt    <= c_wait_init;
        r_port_d <= w_sel_d;
        r_we     <= w_sel_we;
        r_addr   <= w_sel_addr;
        r_wdata  <= w_sel_wdata;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_i_rvalid <= w_enter_resp & ~w_sel_d;
      r_d_rvalid <= w_enter_resp & w_sel_d;
      r_err      <= w_enter_resp & w_oor;
      if (w_enter_resp) begin
        if (w_sel_d) r_d_rdata <= w_resp_word;
        else         r_i_rdata <= w_resp_word;
      end
    end
  end

  // Contents are deliberately not reset; rst only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) mem[w_idx] <= w_sel_wdata;
  end

  assign i_gnt    = w_i_gnt;
  assign d_gnt    = w_d_gnt;
  assign i_rvalid = r_i_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;
  assign busy     = (r_state != S_IDLE);
`ifdef MEMRESP_ERR_EN
  assign err      = r_err;
`else
  logic w_unused_err;
  assign w_unused_err = r_err;
`endif

endmodule
`default_nettype wire
